// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_mul_pkg;

  // Operand class after unpacking; subnormals are folded into CLS_ZERO.
  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_cls_e;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Exponent bias for an exponent field of exp_w bits.
  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN {0, all-ones, 1, 0...}, right-aligned in 64 bits.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return (exp_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Class from the three field predicates of one operand.
  function automatic fp_cls_e fp_classify(input logic exp_zero, input logic exp_ones,
                                          input logic frac_zero);
    fp_cls_e cls;
    cls = CLS_NORM;
    if (exp_zero)
      cls = CLS_ZERO;
    else if (exp_ones)
      cls = frac_zero ? CLS_INF : CLS_NAN;
    return cls;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Final stage: normalise the raw product, round to nearest even, pack, and
// select special results. Purely combinational so it can be registered by
// whichever pipeline wraps it.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                      sign,
  input  fp_cls_e                   cls_a,
  input  fp_cls_e                   cls_b,
  input  logic signed [EXP_W+1:0]   exp_sum,
  input  logic [2*MAN_W+1:0]        prod,
  output logic [EXP_W+MAN_W:0]      result,
  output logic [FLAG_W-1:0]         flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SE = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [SE-1:0] EXP_MAX   = SE'((1 << EXP_W) - 1);
  localparam logic [63:0]          QNAN_FULL = fp_qnan(EXP_W, MAN_W);

  logic [PW-1:0]          prod_n;
  logic [MAN_W:0]         man_keep;
  logic                   guard, rnd, sticky, inc;
  logic [MAN_W+1:0]       man_rnd;
  logic [MAN_W-1:0]       frac_out;
  logic signed [SE-1:0]   exp_n, exp_r;
  logic                   any_nan, any_inf, any_zero;

  // Normalise so the leading one sits in the MSB, then round to nearest even.
  // A product below 2.0 is shifted left instead of the wide one shifted right;
  // both leave the same kept/guard/round/sticky split.
  always_comb begin
    prod_n = prod;
    exp_n  = exp_sum;
    if (prod[PW-1])
      exp_n = exp_sum + SE'(1);
    else
      prod_n = prod << 1;

    man_keep = prod_n[PW-1 -: MAN_W+1];
    guard    = prod_n[MAN_W];
    rnd      = prod_n[MAN_W-1];
    sticky   = |prod_n[MAN_W-2:0];
    inc      = guard & (rnd | sticky | man_keep[0]);
    man_rnd  = {1'b0, man_keep} + {{(MAN_W+1){1'b0}}, inc};

    frac_out = man_rnd[MAN_W-1:0];
    exp_r    = exp_n;
    if (man_rnd[MAN_W+1]) begin
      frac_out = '0;
      exp_r    = exp_n + SE'(1);
    end
  end

  // Special-case select, highest priority first; range checks use the
  // post-rounding exponent.
  always_comb begin
    any_nan  = (cls_a == CLS_NAN)  | (cls_b == CLS_NAN);
    any_inf  = (cls_a == CLS_INF)  | (cls_b == CLS_INF);
    any_zero = (cls_a == CLS_ZERO) | (cls_b == CLS_ZERO);
    result   = '0;
    flags    = '0;
    if (any_nan | (any_inf & any_zero)) begin
      result               = QNAN_FULL[W-1:0];
      flags[FLAG_INVALID]  = 1'b1;
    end else if (any_inf) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (any_zero) begin
      result = {sign, {(W-1){1'b0}}};
    end else if (exp_r >= EXP_MAX) begin
      result               = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_r <= SE'(0)) begin
      result                = {sign, {(W-1){1'b0}}};
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end else begin
      result              = {sign, exp_r[EXP_W-1:0], frac_out};
      flags[FLAG_INEXACT] = guard | rnd | sticky;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with a global stall: unpack/classify,
// mantissa multiply, then normalise/round/pack into the output register.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic [FLAG_W-1:0]      out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SE = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [SE-1:0] BIAS = SE'(fp_bias(EXP_W));

  logic                  adv;
  logic [EXP_W-1:0]      exp_a, exp_b;
  logic [MAN_W-1:0]      frac_a, frac_b;
  fp_cls_e               cls_a_c, cls_b_c;
  logic signed [SE-1:0]  exp_sum_c;

  logic                  s1_valid, s1_sign;
  fp_cls_e               s1_cls_a, s1_cls_b;
  logic signed [SE-1:0]  s1_exp;
  logic [MAN_W:0]        s1_man_a, s1_man_b;
  logic [TAG_W-1:0]      s1_tag;

  logic                  s2_valid, s2_sign;
  fp_cls_e               s2_cls_a, s2_cls_b;
  logic signed [SE-1:0]  s2_exp;
  logic [PW-1:0]         s2_prod;
  logic [TAG_W-1:0]      s2_tag;

  logic [W-1:0]          rnd_result;
  logic [FLAG_W-1:0]     rnd_flags;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign exp_a  = in_a[W-2 -: EXP_W];
  assign exp_b  = in_b[W-2 -: EXP_W];
  assign frac_a = in_a[MAN_W-1:0];
  assign frac_b = in_b[MAN_W-1:0];

  // S1 combinational: classify operands and form the biased exponent sum.
  always_comb begin
    cls_a_c   = fp_classify(exp_a == '0, &exp_a, frac_a == '0);
    cls_b_c   = fp_classify(exp_b == '0, &exp_b, frac_b == '0);
    exp_sum_c = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
  end

  // S1 register: unpacked operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls_a <= CLS_ZERO;
      s1_cls_b <= CLS_ZERO;
      s1_exp   <= '0;
      s1_man_a <= '0;
      s1_man_b <= '0;
      s1_tag   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= in_a[W-1] ^ in_b[W-1];
      s1_cls_a <= cls_a_c;
      s1_cls_b <= cls_b_c;
      s1_exp   <= exp_sum_c;
      s1_man_a <= {1'b1, frac_a};
      s1_man_b <= {1'b1, frac_b};
      s1_tag   <= in_tag;
    end
  end

  // S2 register: full-width mantissa product, classification carried along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_cls_a <= CLS_ZERO;
      s2_cls_b <= CLS_ZERO;
      s2_exp   <= '0;
      s2_prod  <= '0;
      s2_tag   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_cls_a <= s1_cls_a;
      s2_cls_b <= s1_cls_b;
      s2_exp   <= s1_exp;
      s2_prod  <= PW'(s1_man_a) * PW'(s1_man_b);
      s2_tag   <= s1_tag;
    end
  end

  fp_mul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign    (s2_sign),
    .cls_a   (s2_cls_a),
    .cls_b   (s2_cls_b),
    .exp_sum (s2_exp),
    .prod    (s2_prod),
    .result  (rnd_result),
    .flags   (rnd_flags)
  );

  // S3 / output register; data only reloads on a real result so bubbles
  // leave the last product visible but invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_result <= rnd_result;
        out_tag    <= s2_tag;
        out_flags  <= rnd_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
module tb_fp_mul_pipe;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [3:0]  flags;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0]  in_tag, out_tag, out_flags;

  logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h;
  logic [15:0] in_a_h, in_b_h, out_result_h;
  logic [3:0]  in_tag_h, out_tag_h, out_flags_h;

  exp_t        q[$];
  exp_t        q_h[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        stall_prev = 1'b0;
  logic [39:0] held = '0;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid_h),
    .in_ready   (in_ready_h),
    .in_a       (in_a_h),
    .in_b       (in_b_h),
    .in_tag     (in_tag_h),
    .out_valid  (out_valid_h),
    .out_ready  (out_ready_h),
    .out_result (out_result_h),
    .out_tag    (out_tag_h),
    .out_flags  (out_flags_h)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor for the single-precision instance: result/tag/flags against the
  // scoreboard on every handshake, plus output stability across stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {24'd0, out_result, out_tag, out_flags}, {24'd0, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got result %h tag %h, required no output",
                   out_result, out_tag);
        end else begin
          check("result", out_result, q[0].res);
          check("tag", out_tag, q[0].tag);
          check("flags", out_flags, q[0].flags);
          void'(q.pop_front());
        end
      end
      stall_prev <= out_valid && !out_ready;
      held       <= {out_result, out_tag, out_flags};
    end
  end

  // Monitor for the half-precision instance.
  always @(negedge clk) begin
    if (rst_n && out_valid_h && out_ready_h) begin
      if (q_h.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output_h: got result %h tag %h, required no output",
                 out_result_h, out_tag_h);
      end else begin
        check("result_h", {16'd0, out_result_h}, q_h[0].res);
        check("tag_h", out_tag_h, q_h[0].tag);
        check("flags_h", out_flags_h, q_h[0].flags);
        void'(q_h.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      input logic [31:0] r, input logic [3:0] f, input bit push);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: tag %0d not accepted, required acceptance within 50 cycles", tag);
    end else if (push) begin
      q.push_back('{res: r, tag: tag, flags: f});
    end
  endtask

  task automatic send_h(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                        input logic [15:0] r, input logic [3:0] f);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    in_valid_h = 1'b1;
    in_a_h     = a;
    in_b_h     = b;
    in_tag_h   = tag;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready_h;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid_h = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout_h: tag %0d not accepted, required acceptance within 50 cycles", tag);
    end else begin
      q_h.push_back('{res: {16'd0, r}, tag: tag, flags: f});
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q_h.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", q.size() + q_h.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_tag      = '0;
    out_ready   = 1'b1;
    in_valid_h  = 1'b0;
    in_a_h      = '0;
    in_b_h      = '0;
    in_tag_h    = '0;
    out_ready_h = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_flags", out_flags, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);

    // Basic product and exact 3-cycle latency.
    send(32'h3FC00000, 32'h40000000, 4'd5, 32'h40400000, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    check("latency_c2_valid", out_valid, 0);
    @(posedge clk);
    #1;
    check("latency_c3_valid", out_valid, 1);
    drain();

    // Rounding, overflow, specials, underflow, flushed subnormal.
    send(32'h3F800001, 32'h3FC00000, 4'd1, 32'h3FC00002, 4'b0001, 1'b1);
    send(32'h7F000000, 32'h7F000000, 4'd2, 32'h7F800000, 4'b0101, 1'b1);
    send(32'h7F800000, 32'h00000000, 4'd3, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'h80000000, 32'h40A00000, 4'd4, 32'h80000000, 4'b0000, 1'b1);
    send(32'h7F800001, 32'h3F800000, 4'd6, 32'h7FC00000, 4'b1000, 1'b1);
    send(32'h00800000, 32'h3F000000, 4'd7, 32'h00000000, 4'b0011, 1'b1);
    send(32'h00000001, 32'h40000000, 4'd8, 32'h00000000, 4'b0000, 1'b1);
    drain();

    // Half-precision instance.
    send_h(16'h3E00, 16'h4000, 4'd3, 16'h4200, 4'b0000);
    send_h(16'h3C00, 16'h3C00, 4'd4, 16'h3C00, 4'b0000);
    send_h(16'h7800, 16'h7800, 4'd6, 16'h7C00, 4'b0101);
    drain();

    // Backpressure: six back-to-back ops, consumer stalls for three cycles.
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 4'd1, 32'h3F800000, 4'b0000, 1'b1);
        send(32'h40000000, 32'h40000000, 4'd2, 32'h40800000, 4'b0000, 1'b1);
        send(32'h3FC00000, 32'h3FC00000, 4'd3, 32'h40100000, 4'b0000, 1'b1);
        send(32'h40400000, 32'h3F000000, 4'd4, 32'h3FC00000, 4'b0000, 1'b1);
        send(32'hC0000000, 32'h40400000, 4'd5, 32'hC0C00000, 4'b0000, 1'b1);
        send(32'h40800000, 32'h3E800000, 4'd6, 32'h3F800000, 4'b0000, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_out_valid", out_valid, 1);
          check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight: none of them may surface.
    out_ready = 1'b0;
    send(32'h40000000, 32'h40000000, 4'd10, 32'h0, 4'b0000, 1'b0);
    send(32'h40400000, 32'h40000000, 4'd11, 32'h0, 4'b0000, 1'b0);
    send(32'h3F800000, 32'h40000000, 4'd12, 32'h0, 4'b0000, 1'b0);
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_result", out_result, 0);
    check("mid_rst_out_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_result", seen, 0);
    check("post_rst_in_ready", in_ready, 1);

    send(32'h40000000, 32'h40400000, 4'd9, 32'h40C00000, 4'b0000, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier. It is the sequential successor to the team's single-cycle fp32 multiplier.
- Adds configurable exponent and mantissa widths, a 3-stage pipeline with valid/ready backpressure, and round-to-nearest-even.
- Adds proper handling of zero, infinity and NaN, signed zeros, a sideband tag, and exception flags.
- Sits between operand buffers and the accumulator/comparison datapath of the approximate-multiplier test harness.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width (hidden bit implicit)
TAG_W, 4, width of sideband tag carried alongside each operation

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  pipeline can accept operands this cycle
in_a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}
in_b  in  1+EXP_W+MAN_W  operand B
in_tag  in  TAG_W  sideband tag, returned unchanged with result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  1+EXP_W+MAN_W  product
out_tag  out  TAG_W  tag of this result
out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset (async, rst_n=0):
  - all stage valid bits cleared immediately;
  - out_valid=0, out_result=0, out_tag=0, out_flags=0;
  - in_ready=1 after reset releases.
- Reset mid-operation discards every in-flight operation. No result is emitted for it.
- Pipeline advance:
  - adv = out_ready | ~out_valid;
  - in_ready = adv;
  - the whole pipe shifts only when adv=1 (global stall).
- Handshakes:
  - an input is accepted on in_valid & in_ready;
  - an output is consumed on out_valid & out_ready;
  - while stalled, out_result/out_tag/out_flags hold stable.
- Latency is exactly 3 cycles from acceptance to out_valid when not stalled. Throughput is 1 per cycle.
- Bubbles: an empty stage is overwritten freely. Stage valid bits propagate with the data.
- S1, unpack/classify:
  - sign = sa^sb;
  - classify each operand as zero (exp==0; subnormals are flushed to zero), inf (exp all-ones, frac==0), or NaN (exp all-ones, frac!=0);
  - biased exponent sum e = ea+eb-bias, held as a signed EXP_W+2-bit value;
  - mantissas are {1,frac}.
- S2: full (MAN_W+1)x(MAN_W+1) product, 2*MAN_W+2 bits. Classification and exponent are carried forward.
- S3, normalise:
  - if product MSB=1, shift right by 1 and e+=1;
  - guard = next bit below LSB, round = bit below guard, sticky = OR of the remaining bits.
- S3, RNE rounding:
  - increment when g & (r|s|lsb);
  - a mantissa carry-out sets the mantissa to 1.0 and e+=1, evaluated after rounding;
  - inexact = g|r|s.
- Special-case priority, highest first:
  1. any NaN, or inf*zero → canonical quiet NaN {0, all-ones, 1, 0...}, invalid=1;
  2. inf operand → signed inf;
  3. zero operand → signed zero ({sign, 0...});
  4. e >= 2^EXP_W-1 after rounding → signed inf, overflow=1, inexact=1;
  5. e <= 0 → signed zero (flush), underflow=1, inexact=1;
  6. otherwise normal pack.
- Special results (priorities 1–3) carry no inexact flag.
- All flags are per-result, not sticky.

Decomposition:
- Shared package fp_mul_pkg holds:
  - class encoding enum (ZERO, NORM, INF, NAN);
  - function for bias from EXP_W;
  - canonical-NaN constructor;
  - flag bit index constants.
- One natural sub-module, fp_mul_round: the combinational S3 normalise/round/pack and special-case select. It is reused later by the approximate variant.

Test Plan:
1. Basic product: A=0x3FC00000, B=0x40000000, tag=5 → 3 cycles later 0x40400000, tag 5, flags 0000.
2. RNE tie and overflow:
   - A=0x3F800001, B=0x3FC00000 → 0x3FC00002, inexact=1 (tie rounds to even);
   - A=0x7F000000 × itself → 0x7F800000, overflow+inexact.
3. Specials:
   - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1;
   - 0x80000000 × 0x40A00000 → 0x80000000, flags 0;
   - NaN 0x7F800001 × 1.0 → 0x7FC00000, invalid.
4. Underflow: 0x00800000 × 0x3F000000 → 0x00000000, underflow+inexact. Subnormal input 0x00000001 × 2.0 → 0x00000000, flags 0.
5. Backpressure:
   - stream 6 ops back-to-back with out_ready low on cycles 4–6;
   - in_ready must drop and outputs must hold;
   - all 6 results emerge in order with the correct tags, with no loss or duplication.
6. Reset mid-stream and parametrisation:
   - assert rst_n low with 3 ops in flight → out_valid=0 immediately, and no stale result after release;
   - rerun scenario 1 at EXP_W=5, MAN_W=10: 0x3E00 × 0x4000 → 0x4200.
